// File: rtl/buzzer_melody_scheduler_pkg.sv
// Shared types for the buzzer melody scheduler: note codes, melody ids, FSM states, ROM word.
package buzzer_melody_scheduler_pkg;

  localparam int unsigned NUM_MEL    = 4;
  localparam int unsigned MEL_W      = 2;
  localparam int unsigned STEP_W     = 3;
  localparam int unsigned NOTE_VEC_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_NOTE,
    ST_GAP,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    N_REST = 3'd0,
    N_DO   = 3'd1,
    N_RE   = 3'd2,
    N_MI   = 3'd3,
    N_FA   = 3'd4,
    N_SOL  = 3'd5,
    N_LA   = 3'd6,
    N_SI   = 3'd7
  } note_e;

  typedef enum logic [MEL_W-1:0] {
    MEL_ALARM = 2'd0,
    MEL_SLEEP = 2'd1,
    MEL_PLAY  = 2'd2,
    MEL_FEED  = 2'd3
  } mel_e;

  typedef struct packed {
    note_e      note;
    logic [2:0] dur;
    logic       last;
  } rom_word_t;

  // Build a ROM word from a note and its length in ticks (1..8).
  function automatic rom_word_t rw(input note_e n, input int unsigned ticks, input logic last);
    rom_word_t w;
    w.note = n;
    w.dur  = 3'(ticks - 1);
    w.last = last;
    return w;
  endfunction

  // Note code to one-hot enable vector; bit (code-1), REST gives all zeros.
  function automatic logic [NOTE_VEC_W-1:0] note_onehot(input note_e n);
    if (n == N_REST) return '0;
    return NOTE_VEC_W'(7'd1 << (3'(n) - 3'd1));
  endfunction

endpackage

// File: rtl/buzzer_melody_scheduler_rom.sv
// Melody table: (melody id, step) -> {note, dur, last}; unused steps read as a final rest.
module melody_rom
  import buzzer_melody_scheduler_pkg::*;
(
  input  logic [MEL_W-1:0]  mel,
  input  logic [STEP_W-1:0] step,
  output rom_word_t         rom_word
);

  always_comb begin
    rom_word = rw(N_REST, 1, 1'b1);
    case ({mel, step})
      {MEL_ALARM, 3'd0}: rom_word = rw(N_LA,  2, 1'b0);
      {MEL_ALARM, 3'd1}: rom_word = rw(N_SI,  2, 1'b0);
      {MEL_ALARM, 3'd2}: rom_word = rw(N_LA,  2, 1'b0);
      {MEL_ALARM, 3'd3}: rom_word = rw(N_SI,  2, 1'b1);
      {MEL_SLEEP, 3'd0}: rom_word = rw(N_SOL, 4, 1'b0);
      {MEL_SLEEP, 3'd1}: rom_word = rw(N_MI,  4, 1'b0);
      {MEL_SLEEP, 3'd2}: rom_word = rw(N_DO,  8, 1'b1);
      {MEL_PLAY,  3'd0}: rom_word = rw(N_DO,  1, 1'b0);
      {MEL_PLAY,  3'd1}: rom_word = rw(N_MI,  1, 1'b0);
      {MEL_PLAY,  3'd2}: rom_word = rw(N_SOL, 1, 1'b0);
      {MEL_PLAY,  3'd3}: rom_word = rw(N_DO,  2, 1'b0);
      {MEL_PLAY,  3'd4}: rom_word = rw(N_REST, 1, 1'b0);
      {MEL_PLAY,  3'd5}: rom_word = rw(N_SOL, 2, 1'b1);
      {MEL_FEED,  3'd0}: rom_word = rw(N_DO,  1, 1'b0);
      {MEL_FEED,  3'd1}: rom_word = rw(N_MI,  1, 1'b0);
      {MEL_FEED,  3'd2}: rom_word = rw(N_SOL, 2, 1'b1);
      default:           rom_word = rw(N_REST, 1, 1'b1);
    endcase
  end

endmodule

// File: rtl/buzzer_melody_scheduler.sv
// Priority melody scheduler: queues sound requests, plays stored melodies as one-hot note
// enables with per-note articulation gaps; higher-priority requests preempt.
module buzzer_melody_scheduler
  import buzzer_melody_scheduler_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 6_250_000,
  parameter int unsigned GAP_CYCLES  = 500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_MEL-1:0]  req,
  input  logic                mute,
  output logic                LA,
  output logic                DO,
  output logic                MI,
  output logic                SOL,
  output logic                RE,
  output logic                FA,
  output logic                SI,
  output logic                busy,
  output logic [MEL_W-1:0]    cur_mel,
  output logic                done
);

  localparam int unsigned DUR_CNT_W = $clog2(8 * TICK_CYCLES);
  localparam int unsigned GAP_CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e                  state_q, state_d;
  logic [NUM_MEL-1:0]      pending_q, pending_d;
  logic [MEL_W-1:0]        cur_mel_q, cur_mel_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [DUR_CNT_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [GAP_CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                    last_q, last_d;
  logic [NOTE_VEC_W-1:0]   notes_q, notes_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [MEL_W-1:0]        grant;
  logic [MEL_W-1:0]        rom_mel;
  logic [STEP_W-1:0]       rom_step;
  rom_word_t               rom_word;
  logic [DUR_CNT_W-1:0]    dur_load;
  logic                    playing;
  logic                    preempt;
  logic [NUM_MEL-1:0]      higher_mask;

  // Lowest set pending bit wins.
  always_comb begin
    grant = '0;
    for (int i = int'(NUM_MEL) - 1; i >= 0; i--) begin
      if (pending_q[i]) grant = MEL_W'(i);
    end
  end

  // ROM is read for the first step on grant, otherwise for the step about to start.
  assign rom_mel  = (state_q == ST_LOAD) ? grant : cur_mel_q;
  assign rom_step = (state_q == ST_LOAD) ? '0 : STEP_W'(step_q + 3'd1);

  melody_rom u_rom (
    .mel      (rom_mel),
    .step     (rom_step),
    .rom_word (rom_word)
  );

  assign dur_load    = DUR_CNT_W'((32'(rom_word.dur) + 32'd1) * TICK_CYCLES - 32'd1);
  assign playing     = (state_q == ST_NOTE) || (state_q == ST_GAP);
  assign higher_mask = NUM_MEL'((4'd1 << cur_mel_q) - 4'd1);
  assign preempt     = playing && |(pending_q & higher_mask);

  // Next-state and next-output logic.
  always_comb begin
    logic [NUM_MEL-1:0] clr;
    logic [NUM_MEL-1:0] ignore;
    logic               advance;
    logic               load_note;

    state_d   = state_q;
    pending_d = pending_q;
    cur_mel_d = cur_mel_q;
    step_d    = step_q;
    dur_cnt_d = dur_cnt_q;
    gap_cnt_d = gap_cnt_q;
    last_d    = last_q;
    notes_d   = notes_q;
    done_d    = 1'b0;
    busy_d    = 1'b0;
    clr       = '0;
    ignore    = playing ? NUM_MEL'(4'd1 << cur_mel_q) : '0;
    advance   = 1'b0;
    load_note = 1'b0;

    case (state_q)
      ST_IDLE: if (|pending_q) state_d = ST_LOAD;
      ST_LOAD: begin
        cur_mel_d  = grant;
        step_d     = '0;
        clr[grant] = 1'b1;
        load_note  = 1'b1;
      end
      ST_NOTE: begin
        if (preempt) begin
          state_d = ST_LOAD;
        end else if (dur_cnt_q == '0) begin
          if (GAP_CYCLES == 0) begin
            advance = 1'b1;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_CNT_W'(GAP_CYCLES - 1);
          end
        end else begin
          dur_cnt_d = dur_cnt_q - DUR_CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (preempt) state_d = ST_LOAD;
        else if (gap_cnt_q == '0) advance = 1'b1;
        else gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
      end
      ST_DONE: state_d = (|pending_q) ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (last_q) begin
        state_d = ST_DONE;
      end else begin
        step_d    = STEP_W'(step_q + 3'd1);
        load_note = 1'b1;
      end
    end

    if (load_note) begin
      state_d   = ST_NOTE;
      notes_d   = note_onehot(rom_word.note);
      last_d    = rom_word.last;
      dur_cnt_d = dur_load;
    end

    if (state_d != ST_NOTE) notes_d = '0;

    // A request for the melody currently sounding is dropped; a new request beats a grant clear.
    pending_d = (pending_q & ~clr) | (req & ~ignore);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      cur_mel_q <= '0;
      step_q    <= '0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      last_q    <= 1'b0;
      notes_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_mel_q <= cur_mel_d;
      step_q    <= step_d;
      dur_cnt_q <= dur_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      last_q    <= last_d;
      notes_q   <= notes_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Mute only gates the enables; sequencing keeps running underneath.
  assign DO  = notes_q[0] & ~mute;
  assign RE  = notes_q[1] & ~mute;
  assign MI  = notes_q[2] & ~mute;
  assign FA  = notes_q[3] & ~mute;
  assign SOL = notes_q[4] & ~mute;
  assign LA  = notes_q[5] & ~mute;
  assign SI  = notes_q[6] & ~mute;

  assign busy    = busy_q;
  assign cur_mel = cur_mel_q;
  assign done    = done_q;

endmodule

// File: tb/tb_buzzer_melody_scheduler.sv
// Bench for buzzer_melody_scheduler: directed scenarios plus random requests, checked each cycle
// against a melody-table model that expands each granted melody into its per-cycle note sequence.
module tb_buzzer_melody_scheduler;

  localparam int unsigned TICK = 4;
  localparam int unsigned GAP  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       mute;
  logic       LA, DO, MI, SOL, RE, FA, SI;
  logic       busy;
  logic [1:0] cur_mel;
  logic       done;
  logic [6:0] notes_obs;

  always #5 clk = ~clk;

  buzzer_melody_scheduler #(.TICK_CYCLES(TICK), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mute(mute),
    .LA(LA), .DO(DO), .MI(MI), .SOL(SOL), .RE(RE), .FA(FA), .SI(SI),
    .busy(busy), .cur_mel(cur_mel), .done(done)
  );

  assign notes_obs = {SI, LA, SOL, FA, MI, RE, DO};

  // Melody table as written: note code and length in ticks per step.
  int mel_len [4] = '{4, 3, 6, 3};
  int mel_note[4][6] = '{'{6, 7, 6, 7, 0, 0}, '{5, 3, 1, 0, 0, 0},
                         '{1, 3, 5, 1, 0, 5}, '{1, 3, 5, 0, 0, 0}};
  int mel_tick[4][6] = '{'{2, 2, 2, 2, 0, 0}, '{4, 4, 8, 0, 0, 0},
                         '{1, 1, 1, 2, 1, 2}, '{1, 1, 2, 0, 0, 0}};

  // Model: phase 0 idle, 1 granting, 2 playing (queue holds remaining cycles), 3 finished.
  int         m_ph;
  int         m_mel;
  logic [3:0] m_pend;
  logic [6:0] m_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  function automatic logic [6:0] onehot(input int code);
    logic [6:0] v;
    v = '0;
    if (code != 0) v[code-1] = 1'b1;
    return v;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic rn);
    logic [3:0] p, clr, ign;
    int g;
    if (!rn) begin
      m_ph = 0; m_mel = 0; m_pend = '0; m_q.delete();
      return;
    end
    p   = m_pend;
    clr = '0;
    ign = '0;
    if (m_ph == 2) ign[m_mel] = 1'b1;
    case (m_ph)
      0: if (p != 0) m_ph = 1;
      1: begin
        g = 0;
        while (!p[g]) g++;
        m_mel  = g;
        clr[g] = 1'b1;
        m_q.delete();
        for (int s = 0; s < mel_len[g]; s++) begin
          repeat (mel_tick[g][s] * TICK) m_q.push_back(onehot(mel_note[g][s]));
          repeat (GAP) m_q.push_back(7'd0);
        end
        m_ph = 2;
      end
      2: begin
        logic hi;
        hi = 1'b0;
        for (int j = 0; j < m_mel; j++) if (p[j]) hi = 1'b1;
        if (hi) begin
          m_ph = 1;
          m_q.delete();
        end else begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_ph = 3;
        end
      end
      default: m_ph = (p != 0) ? 1 : 0;
    endcase
    m_pend = (p & ~clr) | (r & ~ign);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic m);
    logic [6:0] exp_notes;
    exp_notes = (m_ph == 2) ? (m_q[0] & ~{7{m}}) : 7'd0;
    chk("busy", 8'(busy), 8'(m_ph != 0));
    chk("done", 8'(done), 8'(m_ph == 3));
    chk("notes", 8'(notes_obs), 8'(exp_notes));
    chk("onehot", 8'($countones(notes_obs) <= 1), 8'd1);
    if (m_ph >= 2) chk("cur_mel", 8'(cur_mel), 8'(m_mel));
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic cyc(input logic [3:0] r, input logic m, input logic rn);
    req = r; mute = m; rst_n = rn;
    @(posedge clk);
    model_edge(r, rn);
    #1;
    check_outputs(m);
  endtask

  task automatic run(input int n, input logic m);
    repeat (n) cyc(4'b0000, m, 1'b1);
  endtask

  initial begin
    req = '0; mute = 1'b0; rst_n = 1'b0;
    m_ph = 0; m_mel = 0; m_pend = '0;

    // Reset state
    repeat (3) cyc(4'b0000, 1'b0, 1'b0);
    chk("reset_cur_mel", 8'(cur_mel), 8'd0);

    // FEED alone
    done_cnt = 0;
    cyc(4'b1000, 1'b0, 1'b1);
    run(30, 1'b0);
    chk("feed_done_count", 8'(done_cnt), 8'd1);
    chk("feed_idle", 8'(busy), 8'd0);

    // ALARM preempts FEED during its first MI
    done_cnt = 0;
    cyc(4'b1000, 1'b0, 1'b1);
    run(8, 1'b0);
    chk("preempt_mi_high", 8'(MI), 8'd1);
    cyc(4'b0001, 1'b0, 1'b1);
    run(50, 1'b0);
    chk("preempt_done_count", 8'(done_cnt), 8'd1);

    // SLEEP and PLAY requested together
    done_cnt = 0;
    cyc(4'b0110, 1'b0, 1'b1);
    run(125, 1'b0);
    chk("queue_done_count", 8'(done_cnt), 8'd2);

    // Re-request of FEED while it plays
    done_cnt = 0;
    cyc(4'b1000, 1'b0, 1'b1);
    run(6, 1'b0);
    cyc(4'b1000, 1'b0, 1'b1);
    run(30, 1'b0);
    chk("rereq_done_count", 8'(done_cnt), 8'd1);

    // Muted SLEEP
    done_cnt = 0;
    cyc(4'b0010, 1'b1, 1'b1);
    run(80, 1'b1);
    chk("mute_done_count", 8'(done_cnt), 8'd1);

    // Reset mid-note with PLAY pending
    done_cnt = 0;
    cyc(4'b0010, 1'b0, 1'b1);
    run(10, 1'b0);
    cyc(4'b0100, 1'b0, 1'b1);
    run(2, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("reset_mid_busy", 8'(busy), 8'd0);
    run(20, 1'b0);
    chk("reset_no_restart", 8'(busy), 8'd0);
    chk("reset_done_count", 8'(done_cnt), 8'd0);

    // Random requests, mute and occasional reset
    begin
      logic m;
      m = 1'b0;
      for (int i = 0; i < 2500; i++) begin
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 49) == 0) m = ~m;
        cyc(r, m, ($urandom_range(0, 799) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
